// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: recursive Urdhva-Tiryagbhyam multiplier, one level per pipeline stage,
// valid/ready flow control with a tag sideband. Define VEDIC_MUL_SIGNED_EN for per-op signed mode.
module vedic_mul_pipe #(
    parameter  int WIDTH  = 8,
    parameter  int TAG_W  = 4,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef VEDIC_MUL_SIGNED_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy,
    output logic [LEVELS:0]      in_flight
);

    localparam int PROD_W = 2 * WIDTH;
`ifdef VEDIC_MUL_SIGNED_EN
    localparam int DEPTH = LEVELS + 1;
`else
    localparam int DEPTH = LEVELS;
`endif

    function automatic logic [LEVELS:0] count_ones(input logic [DEPTH-1:0] v);
        logic [LEVELS:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {{LEVELS{1'b0}}, v[i]};
        end
        return n;
    endfunction

    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] vld_nxt_s;
    logic [DEPTH-1:0] ld_s;
    logic             stall_s;
    logic             accept_s;
    logic [LEVELS:0]  in_flight_r;
    logic             busy_r;
    logic [TAG_W-1:0] tag_r [DEPTH];
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;

    assign stall_s   = vld_r[DEPTH-1] & ~out_ready;
    assign accept_s  = in_valid & ~stall_s;
    assign in_ready  = ~stall_s;
    assign out_valid = vld_r[DEPTH-1];
    assign out_tag   = tag_r[DEPTH-1];
    assign busy      = busy_r;
    assign in_flight = in_flight_r;

    // Rigid shift of the valid bits; a stage only loads when valid data moves into it
    always_comb begin
        vld_nxt_s = vld_r;
        ld_s      = '0;
        if (stall_s) begin
            vld_nxt_s = vld_r;
            ld_s      = '0;
        end else begin
            vld_nxt_s = {vld_r[DEPTH-2:0], accept_s};
            ld_s      = {vld_r[DEPTH-2:0], accept_s};
        end
    end

    // Valid bits plus occupancy bookkeeping, kept registered alongside the stage bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r       <= '0;
            in_flight_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            vld_r       <= vld_nxt_s;
            in_flight_r <= count_ones(vld_nxt_s);
            busy_r      <= (vld_nxt_s != '0);
        end
    end

    // Tag sideband travels with the operands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            if (ld_s[0]) begin
                tag_r[0] <= in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ld_s[i]) begin
                    tag_r[i] <= tag_r[i-1];
                end
            end
        end
    end

`ifdef VEDIC_MUL_SIGNED_EN
    logic              neg_s;
    logic [LEVELS-1:0] sgn_r;
    logic [PROD_W-1:0] res_r;

    // Signed operands enter the array as magnitudes; the product sign is reapplied at the end
    always_comb begin
        a_mag_s = a;
        b_mag_s = b;
        neg_s   = 1'b0;
        if (in_signed) begin
            a_mag_s = a[WIDTH-1] ? ((~a) + WIDTH'(1)) : a;
            b_mag_s = b[WIDTH-1] ? ((~b) + WIDTH'(1)) : b;
            neg_s   = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            a_mag_s = a;
            b_mag_s = b;
            neg_s   = 1'b0;
        end
    end

    // Sign pipe running in parallel with the multiplier levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sgn_r <= '0;
        end else begin
            if (ld_s[0]) begin
                sgn_r[0] <= neg_s;
            end
            for (int i = 1; i < LEVELS; i++) begin
                if (ld_s[i]) begin
                    sgn_r[i] <= sgn_r[i-1];
                end
            end
        end
    end

    // Extra output stage: conditional two's complement of the magnitude product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_r <= '0;
        end else if (ld_s[DEPTH-1]) begin
            res_r <= sgn_r[LEVELS-1] ? ((~g_lvl[LEVELS].prod_r) + PROD_W'(1)) : g_lvl[LEVELS].prod_r;
        end
    end

    assign result = res_r;
`else
    assign a_mag_s = a;
    assign b_mag_s = b;
    assign result  = g_lvl[LEVELS].prod_r;
`endif

    // Level k holds (WIDTH>>k)^2 products of 2^k-bit slices, each 2^(k+1) bits wide,
    // indexed as a_slice*NK + b_slice.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int NK = WIDTH >> k;
        localparam int PW = 2 << k;

        logic [NK*NK*PW-1:0] prod_r;
        logic [NK*NK*PW-1:0] prod_nxt_s;

        if (k == 1) begin : g_base
            for (genvar i = 0; i < NK; i++) begin : g_i
                for (genvar j = 0; j < NK; j++) begin : g_j
                    assign prod_nxt_s[(i*NK+j)*PW +: PW] =
                        {2'b00, a_mag_s[2*i +: 2]} * {2'b00, b_mag_s[2*j +: 2]};
                end
            end
        end else begin : g_comb
            localparam int NP = 2 * NK;
            localparam int PP = PW / 2;
            localparam int H  = PW / 4;
            for (genvar i = 0; i < NK; i++) begin : g_i
                for (genvar j = 0; j < NK; j++) begin : g_j
                    logic [PP-1:0] hh_s;
                    logic [PP-1:0] hl_s;
                    logic [PP-1:0] lh_s;
                    logic [PP-1:0] ll_s;
                    logic [PP:0]   mid_s;
                    assign hh_s  = g_lvl[k-1].prod_r[((2*i+1)*NP + 2*j+1)*PP +: PP];
                    assign hl_s  = g_lvl[k-1].prod_r[((2*i+1)*NP + 2*j  )*PP +: PP];
                    assign lh_s  = g_lvl[k-1].prod_r[((2*i  )*NP + 2*j+1)*PP +: PP];
                    assign ll_s  = g_lvl[k-1].prod_r[((2*i  )*NP + 2*j  )*PP +: PP];
                    // Cross-term sum keeps its carry bit before being shifted into place
                    assign mid_s = {1'b0, hl_s} + {1'b0, lh_s};
                    assign prod_nxt_s[(i*NK+j)*PW +: PW] =
                        {hh_s, ll_s} + {{(H-1){1'b0}}, mid_s, {H{1'b0}}};
                end
            end
        end

        // Level register advances only when a valid operand set moves into it
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prod_r <= '0;
            end else if (ld_s[k-1]) begin
                prod_r <= prod_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench for vedic_mul_pipe: WIDTH=8 against a queue-based reference model,
// plus directed WIDTH=32 and WIDTH=4 corner products.
module tb_vedic_mul_pipe;

`ifdef VEDIC_MUL_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int DEPTH8 = 3 + EXTRA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] result;
    logic [3:0]  in_flight;

    logic        v32, r32, ov32, or32, busy32;
    logic [31:0] a32, b32;
    logic [3:0]  t32i, t32o;
    logic [63:0] res32;
    logic [5:0]  if32;

    logic        v4, r4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [3:0]  t4i, t4o;
    logic [7:0]  res4;
    logic [2:0]  if4;

`ifdef VEDIC_MUL_SIGNED_EN
    logic in_signed;
    logic sgn_tie = 1'b0;
`endif

    vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .in_tag(in_tag),
`ifdef VEDIC_MUL_SIGNED_EN
        .in_signed(in_signed),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .busy(busy), .in_flight(in_flight)
    );

    vedic_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32),
        .a(a32), .b(b32), .in_tag(t32i),
`ifdef VEDIC_MUL_SIGNED_EN
        .in_signed(sgn_tie),
`endif
        .out_valid(ov32), .out_ready(or32), .result(res32),
        .out_tag(t32o), .busy(busy32), .in_flight(if32)
    );

    vedic_mul_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_ready(r4),
        .a(a4), .b(b4), .in_tag(t4i),
`ifdef VEDIC_MUL_SIGNED_EN
        .in_signed(sgn_tie),
`endif
        .out_valid(ov4), .out_ready(or4), .result(res4),
        .out_tag(t4o), .busy(busy4), .in_flight(if4)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: ops in flight with their age in advancing cycles
    logic [15:0] q_prod[$];
    logic [3:0]  q_tag[$];
    int          q_age[$];
    logic        exp_ov = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic sg);
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        if (sg) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            return 16'(sx * sy);
        end
        return {8'h00, x} * {8'h00, y};
    endfunction

    task automatic check_state();
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("in_flight", 64'(in_flight), 64'(q_age.size()));
        check("busy", 64'(busy), 64'(q_age.size() != 0));
        if (exp_ov) begin
            check("result", 64'(result), 64'(q_prod[0]));
            check("out_tag", 64'(out_tag), 64'(q_tag[0]));
        end
    endtask

    // one clock: check current outputs, drive next inputs, advance the model
    task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [3:0] it, input logic ordy, input logic sg);
        logic stall;
        @(negedge clk);
        check_state();
        in_valid  = iv;
        a         = ia;
        b         = ib;
        in_tag    = it;
        out_ready = ordy;
`ifdef VEDIC_MUL_SIGNED_EN
        in_signed = sg;
`endif
        #1;
        stall = exp_ov && !ordy;
        check("in_ready", 64'(in_ready), 64'(!stall));
        if (!stall) begin
            if (exp_ov) begin
                void'(q_prod.pop_front());
                void'(q_tag.pop_front());
                void'(q_age.pop_front());
            end
            foreach (q_age[k]) q_age[k] = q_age[k] + 1;
            if (iv) begin
                q_prod.push_back(ref_mul(ia, ib, sg));
                q_tag.push_back(it);
                q_age.push_back(1);
            end
        end
        exp_ov = (q_age.size() != 0) && (q_age[0] == DEPTH8);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        in_valid = 1'b0; a = 8'h00; b = 8'h00; in_tag = 4'h0; out_ready = 1'b1;
`ifdef VEDIC_MUL_SIGNED_EN
        in_signed = 1'b0;
`endif
        v32 = 1'b0; a32 = 32'h0; b32 = 32'h0; t32i = 4'h0; or32 = 1'b1;
        v4  = 1'b0; a4  = 4'h0;  b4  = 4'h0;  t4i  = 4'h0; or4  = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_flight", 64'(in_flight), 64'd0);
        check("rst_result32", res32, 64'd0);
        check("rst_result4", 64'(res4), 64'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // single op 0x0F*0x0F tag 3
        cycle(1'b1, 8'h0F, 8'h0F, 4'd3, 1'b1, 1'b0);
        idle(DEPTH8);
        check("single_result", 64'(result), 64'h00E1);
        check("single_tag", 64'(out_tag), 64'd3);
        idle(3);

        // back-to-back stream
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 8'(255 - i), 4'(i), 1'b1, 1'b0);
        idle(DEPTH8 + 2);

        // backpressure with three ops in flight
        cycle(1'b1, 8'h11, 8'h22, 4'd5, 1'b1, 1'b0);
        cycle(1'b1, 8'hFE, 8'hFD, 4'd6, 1'b1, 1'b0);
        cycle(1'b1, 8'h9C, 8'h07, 4'd7, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 8'hAA, 8'h55, 4'hF, 1'b0, 1'b0);
        idle(DEPTH8 + 3);

        // exact top corner
        cycle(1'b1, 8'hFF, 8'hFF, 4'd2, 1'b1, 1'b0);
        idle(DEPTH8);
        check("ff_ff", 64'(result), 64'hFE01);
        idle(2);

        // random traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            logic sg;
            sg = 1'b0;
`ifdef VEDIC_MUL_SIGNED_EN
            sg = 1'($urandom_range(0, 1));
`endif
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 4'($urandom),
                  1'($urandom_range(0, 3) != 0), sg);
        end
        idle(DEPTH8 + 3);

`ifdef VEDIC_MUL_SIGNED_EN
        cycle(1'b1, 8'hFF, 8'h02, 4'd1, 1'b1, 1'b1);
        idle(DEPTH8);
        check("signed_ff_02", 64'(result), 64'hFFFE);
        cycle(1'b1, 8'hFF, 8'h02, 4'd2, 1'b1, 1'b0);
        idle(DEPTH8);
        check("unsigned_ff_02", 64'(result), 64'h01FE);
        cycle(1'b1, 8'h80, 8'h7F, 4'd3, 1'b1, 1'b1);
        cycle(1'b1, 8'h80, 8'h80, 4'd4, 1'b1, 1'b1);
        idle(DEPTH8 + 2);
`endif

        // asynchronous reset mid-clock with two ops in flight
        cycle(1'b1, 8'h21, 8'h43, 4'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'h55, 8'h66, 4'd2, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_flight", 64'(in_flight), 64'd0);
        q_prod.delete(); q_tag.delete(); q_age.delete();
        exp_ov = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h12, 8'h34, 4'd9, 1'b1, 1'b0);
        idle(DEPTH8);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_result", 64'(result), 64'h03A8);
        check("post_rst_tag", 64'(out_tag), 64'd9);
        idle(3);

        // WIDTH=32 all ones
        @(negedge clk);
        v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; t32i = 4'hA;
        @(negedge clk);
        v32 = 1'b0;
        n = 1;
        while (!ov32 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w32_latency", 64'(n), 64'(5 + EXTRA));
        check("w32_result", res32, 64'hFFFF_FFFE_0000_0001);
        check("w32_tag", 64'(t32o), 64'hA);
        @(negedge clk);
        check("w32_drained", 64'(busy32), 64'd0);

        // WIDTH=4 all ones
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; t4i = 4'h6;
        @(negedge clk);
        v4 = 1'b0;
        n = 1;
        while (!ov4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("w4_latency", 64'(n), 64'(2 + EXTRA));
        check("w4_result", 64'(res4), 64'hE1);
        check("w4_tag", 64'(t4o), 64'h6);
        @(negedge clk);
        check("w4_drained", 64'(if4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
